acq_search_ctrl: RTL

- Sequences one code_gen channel through a serial code-phase acquisition search.
- Loads the G2 PRN key, then dwells a programmable number of dump periods per code bin.
- Slews code_gen by a programmable half-chip step between bins and stops on correlator detection or after 2046 half-chips have been covered.
- Sits between the tracking software/register block and code_gen/accumulator, and drives code_gen's prn_key_enable, prn_key, slew_enable and code_slew.

---
 rtl/acq_search_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/acq_search_ctrl.sv
// Serial code-phase acquisition sequencer for one code_gen channel: load PRN key, dwell, slew, repeat.
// Optional watchdog and timeout output are enabled by defining ACQ_TIMEOUT_EN.
module acq_search_ctrl #(
    parameter int HC_PER_CODE   = 2046,
    parameter int DWELL_W       = 8,
    parameter int DISCARD_DUMPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [9:0]         prn_key_in,
    input  logic [DWELL_W-1:0] dwell_count,
    input  logic [10:0]        slew_step,
    input  logic               dump_enable,
    input  logic               detect,
    output logic               prn_key_enable,
    output logic [9:0]         prn_key,
    output logic               slew_enable,
    output logic [10:0]        code_slew,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [11:0]        hc_offset
`ifdef ACQ_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    localparam int DISC_W = (DISCARD_DUMPS < 2) ? 1 : $clog2(DISCARD_DUMPS + 1);
    localparam logic [DISC_W-1:0] DISC_INIT = DISC_W'(DISCARD_DUMPS);
    localparam logic [11:0] HC_LIMIT = 12'(HC_PER_CODE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        DWELL,
        SLEW,
        DONE
    } state_t;

    state_t             state;
    logic [DISC_W-1:0]  discard_cnt;
    logic [DWELL_W-1:0] dwell_len;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_next;
    logic [11:0]        next_hc;
`ifdef ACQ_TIMEOUT_EN
    logic [19:0]        wdog;
`endif

    assign dwell_next = dwell_cnt + DWELL_W'(1);
    // Offset after the pending slew; at most 2045 + 2047, so 12 bits never wrap.
    assign next_hc    = hc_offset + {1'b0, code_slew};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            discard_cnt    <= '0;
            dwell_len      <= '0;
            dwell_cnt      <= '0;
            prn_key_enable <= 1'b0;
            prn_key        <= '0;
            slew_enable    <= 1'b0;
            code_slew      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            found          <= 1'b0;
            hc_offset      <= '0;
`ifdef ACQ_TIMEOUT_EN
            wdog           <= '0;
            timeout        <= 1'b0;
`endif
        end else if (abort) begin
            state          <= IDLE;
            busy           <= 1'b0;
            prn_key_enable <= 1'b0;
            slew_enable    <= 1'b0;
            done           <= 1'b0;
        end else begin
            prn_key_enable <= 1'b0;
            slew_enable    <= 1'b0;
            done           <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
            if (state == LOAD || dump_enable) begin
                wdog <= '0;
            end else if (busy) begin
                wdog <= wdog + 20'd1;
            end
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        prn_key        <= prn_key_in;
                        dwell_len      <= (dwell_count == '0) ? DWELL_W'(1) : dwell_count;
                        code_slew      <= (slew_step == '0) ? 11'd1 : slew_step;
                        found          <= 1'b0;
                        hc_offset      <= '0;
                        busy           <= 1'b1;
                        prn_key_enable <= 1'b1;
                        state          <= LOAD;
`ifdef ACQ_TIMEOUT_EN
                        timeout        <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    discard_cnt <= DISC_INIT;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    // The dump that straddled the slew (or the key load) carries a mixed integration.
                    if (discard_cnt == '0) begin
                        dwell_cnt <= '0;
                        state     <= DWELL;
                    end else if (dump_enable) begin
                        discard_cnt <= discard_cnt - DISC_W'(1);
                        if (discard_cnt == DISC_W'(1)) begin
                            dwell_cnt <= '0;
                            state     <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (dump_enable) begin
                        if (detect) begin
                            found <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            dwell_cnt <= dwell_next;
                            if (dwell_next == dwell_len) begin
                                if (next_hc >= HC_LIMIT) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= DONE;
                                end else begin
                                    slew_enable <= 1'b1;
                                    state       <= SLEW;
                                end
                            end
                        end
                    end
                end
                SLEW: begin
                    hc_offset   <= next_hc;
                    discard_cnt <= DISC_INIT;
                    state       <= SETTLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
`ifdef ACQ_TIMEOUT_EN
            // A channel with no dumps for 2^20-1 cycles is dead; end the search unsuccessfully.
            if (busy && state != LOAD && !dump_enable && wdog == 20'hFFFFF) begin
                state          <= DONE;
                done           <= 1'b1;
                busy           <= 1'b0;
                found          <= 1'b0;
                slew_enable    <= 1'b0;
                prn_key_enable <= 1'b0;
                timeout        <= 1'b1;
            end
`endif
        end
    end

endmodule
